// File: rtl/id_digit_display.sv
// id_digit_display: captures ID digits into a scrolling history buffer and scans it onto a common-anode 7-segment display
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   step  : one-cycle capture strobe for id
//   id    : 4-bit digit from the ID sequencer
//   an    : active-low digit enables, newest digit on an[0]
//   seg   : active-low segments {g,f,e,d,c,b,a}
//   fill  : count of valid digits held, saturating
module id_digit_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic [3:0]            id,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic [2:0]            fill
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    // fill is only 3 bits wide, so an 8-digit build saturates at 7
    localparam logic [2:0] FILL_MAX = (NUM_DIGITS > 7) ? 3'd7 : 3'(NUM_DIGITS);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [3:0]            digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid;
    logic [PW-1:0]         presc;
    logic [IW-1:0]         scan_idx;
    logic                  tc;

    assign tc = presc == PW'(SCAN_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            digits   <= '{default: '0};
            valid    <= '0;
            fill     <= '0;
            presc    <= '0;
            scan_idx <= '0;
            an       <= '1;
            seg      <= 7'h7F;
        end else begin
            if (step) begin
                digits[0] <= id;
                for (int i = 1; i < NUM_DIGITS; i++) digits[i] <= digits[i-1];
                valid <= {valid[NUM_DIGITS-2:0], 1'b1};
                fill  <= (fill == FILL_MAX) ? fill : fill + 3'd1;
            end
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            // outputs are registered from the pre-edge state, giving one cycle of latency
            an  <= ~(NUM_DIGITS'(1) << scan_idx);
            seg <= valid[scan_idx] ? SEG_LUT[digits[scan_idx]] : 7'h7F;
        end
    end
endmodule

// File: tb/tb_id_digit_display.sv
// tb_id_digit_display: directed self-checking bench for id_digit_display
module tb_id_digit_display;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [3:0] id = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] fill;
    int checks = 0;
    int errors = 0;

    id_digit_display #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .step(step), .id(id),
        .an(an), .seg(seg), .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic [6:0] seg;
    } dec_vec_t;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
    } slot_vec_t;

    dec_vec_t  dec_tbl [16];
    slot_vec_t slot_tbl [4];

    task automatic tick(input logic r, input logic s, input logic [3:0] v);
        reset = r;
        step  = s;
        id    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic [2:0] ef);
        checks++;
        if (an !== ea || seg !== es || fill !== ef) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h fill=%0d, want an=%b seg=%h fill=%0d",
                     name, an, seg, fill, ea, es, ef);
        end
    endtask

    initial begin
        dec_tbl = '{
            '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
            '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}
        };
        slot_tbl = '{
            '{8,  4'b1101, 7'h12}, '{12, 4'b1011, 7'h19},
            '{16, 4'b0111, 7'h30}, '{20, 4'b1110, 7'h02}
        };

        // reset hold and idle scan
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'h0);
        check("reset_state", 4'b1111, 7'h7F, 3'd0);
        for (int n = 1; n <= 17; n++) begin
            tick(1'b0, 1'b0, 4'h0);
            if (n == 1)  check("idle_first_slot", 4'b1110, 7'h7F, 3'd0);
            if (n == 4)  check("idle_slot0_end", 4'b1110, 7'h7F, 3'd0);
            if (n == 5)  check("idle_slot1", 4'b1101, 7'h7F, 3'd0);
            if (n == 9)  check("idle_slot2", 4'b1011, 7'h7F, 3'd0);
            if (n == 13) check("idle_slot3", 4'b0111, 7'h7F, 3'd0);
            if (n == 17) check("idle_wrap", 4'b1110, 7'h7F, 3'd0);
        end

        // partial fill: 1, 0, 8
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b1, 4'h1);
        tick(1'b0, 1'b1, 4'h0);
        tick(1'b0, 1'b1, 4'h8);
        for (int n = 4; n <= 16; n++) begin
            tick(1'b0, 1'b0, 4'h0);
            if (n == 4)  check("partial_idx0", 4'b1110, 7'h00, 3'd3);
            if (n == 8)  check("partial_idx1", 4'b1101, 7'h40, 3'd3);
            if (n == 12) check("partial_idx2", 4'b1011, 7'h79, 3'd3);
            if (n == 16) check("partial_idx3_blank", 4'b0111, 7'h7F, 3'd3);
        end

        // back-to-back steps 1..6, oldest discarded
        tick(1'b1, 1'b0, 4'h0);
        for (int n = 1; n <= 6; n++) tick(1'b0, 1'b1, 4'(n));
        for (int n = 7; n <= 20; n++) begin
            tick(1'b0, 1'b0, 4'h0);
            foreach (slot_tbl[k])
                if (slot_tbl[k].n == n) check($sformatf("burst_slot%0d", k), slot_tbl[k].an, slot_tbl[k].seg, 3'd4);
        end

        // step coinciding with the scan terminal count (edge 24)
        for (int n = 21; n <= 33; n++) begin
            tick(1'b0, n == 24, (n == 24) ? 4'hE : 4'h0);
            if (n == 25) check("tc_step_shifted", 4'b1011, 7'h12, 3'd4);
            if (n == 29) check("tc_step_idx3", 4'b0111, 7'h19, 3'd4);
            if (n == 33) check("tc_step_newest", 4'b1110, 7'h06, 3'd4);
        end

        // single-cycle reset mid-scan
        tick(1'b1, 1'b0, 4'h0);
        check("midscan_reset", 4'b1111, 7'h7F, 3'd0);
        for (int n = 1; n <= 16; n++) begin
            tick(1'b0, 1'b0, 4'h0);
            if (n == 1)  check("post_reset_first", 4'b1110, 7'h7F, 3'd0);
            if (n == 4)  check("post_reset_slot0", 4'b1110, 7'h7F, 3'd0);
            if (n == 8)  check("post_reset_slot1", 4'b1101, 7'h7F, 3'd0);
            if (n == 12) check("post_reset_slot2", 4'b1011, 7'h7F, 3'd0);
            if (n == 16) check("post_reset_slot3", 4'b0111, 7'h7F, 3'd0);
        end

        // decode sweep: one capture per full scan round, checked in slot 0
        tick(1'b1, 1'b0, 4'h0);
        foreach (dec_tbl[k]) begin
            tick(1'b0, 1'b1, dec_tbl[k].id);
            tick(1'b0, 1'b0, 4'h0);
            check($sformatf("decode_%h", dec_tbl[k].id), 4'b1110, dec_tbl[k].seg,
                  (k >= 3) ? 3'd4 : 3'(k + 1));
            for (int j = 0; j < 14; j++) tick(1'b0, 1'b0, 4'h0);
        end

        // id changes without step leave the buffer alone
        tick(1'b0, 1'b0, 4'h3);
        tick(1'b0, 1'b0, 4'h5);
        check("no_step_idx0", 4'b1110, 7'h0E, 3'd4);
        for (int j = 0; j < 4; j++) tick(1'b0, 1'b0, 4'(j * 3));
        check("no_step_idx1", 4'b1101, 7'h06, 3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
